// File: rtl/mss_bus_switch_pkg.sv
// Shared IBP field widths, port-ID sizing and reset level for the bus-switch
// decoder and its order FIFOs.
package mss_bus_switch_pkg;

  localparam int IBP_DSZ_W   = 3;
  localparam int IBP_BSZ_W   = 4;
  localparam int IBP_PROT_W  = 2;
  localparam int IBP_CACHE_W = 4;

  localparam logic RST_LVL = 1'b1;

  function automatic int port_id_w(input int np);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/mss_bus_switch_ord_fifo.sv
// Order FIFO holding target port IDs; head is the port currently owed data or
// a response. Push and pop together are allowed even when full.
module mss_bus_switch_ord_fifo
  import mss_bus_switch_pkg::*;
#(
  parameter int IDW   = 2,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_a,
  input  logic           push_i,
  input  logic [IDW-1:0] id_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output logic [IDW-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [IDW-1:0] mem_q [DEPTH];
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst_a == RST_LVL) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= id_i;
  end

endmodule

// File: rtl/mss_bus_switch_ibp_dec.sv
// IBP address decoder: routes commands to NSLV targets or the default slave
// and steers write data and responses back in strict command order.
module mss_bus_switch_ibp_dec
  import mss_bus_switch_pkg::*;
#(
  parameter int               AW        = 32,
  parameter int               DW        = 64,
  parameter int               NSLV      = 2,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int               OUT_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_a,
  input  logic                   m_ibp_cmd_valid,
  output logic                   m_ibp_cmd_accept,
  input  logic                   m_ibp_cmd_read,
  input  logic [AW-1:0]          m_ibp_cmd_addr,
  input  logic                   m_ibp_cmd_wrap,
  input  logic [IBP_DSZ_W-1:0]   m_ibp_cmd_data_size,
  input  logic [IBP_BSZ_W-1:0]   m_ibp_cmd_burst_size,
  input  logic [IBP_PROT_W-1:0]  m_ibp_cmd_prot,
  input  logic [IBP_CACHE_W-1:0] m_ibp_cmd_cache,
  input  logic                   m_ibp_cmd_lock,
  input  logic                   m_ibp_cmd_excl,
  output logic                   m_ibp_rd_valid,
  output logic                   m_ibp_rd_excl_ok,
  output logic                   m_ibp_err_rd,
  output logic                   m_ibp_rd_last,
  output logic [DW-1:0]          m_ibp_rd_data,
  input  logic                   m_ibp_rd_accept,
  input  logic                   m_ibp_wr_valid,
  input  logic                   m_ibp_wr_last,
  input  logic [DW-1:0]          m_ibp_wr_data,
  input  logic [DW/8-1:0]        m_ibp_wr_mask,
  output logic                   m_ibp_wr_accept,
  output logic                   m_ibp_wr_done,
  output logic                   m_ibp_wr_excl_done,
  output logic                   m_ibp_err_wr,
  input  logic                   m_ibp_wr_resp_accept,
  output logic [NSLV:0]          s_ibp_cmd_valid,
  input  logic [NSLV:0]          s_ibp_cmd_accept,
  output logic                   s_ibp_cmd_read,
  output logic [AW-1:0]          s_ibp_cmd_addr,
  output logic                   s_ibp_cmd_wrap,
  output logic [IBP_DSZ_W-1:0]   s_ibp_cmd_data_size,
  output logic [IBP_BSZ_W-1:0]   s_ibp_cmd_burst_size,
  output logic [IBP_PROT_W-1:0]  s_ibp_cmd_prot,
  output logic [IBP_CACHE_W-1:0] s_ibp_cmd_cache,
  output logic                   s_ibp_cmd_lock,
  output logic                   s_ibp_cmd_excl,
  input  logic [NSLV:0]          s_ibp_rd_valid,
  input  logic [NSLV:0]          s_ibp_rd_excl_ok,
  input  logic [NSLV:0]          s_ibp_err_rd,
  input  logic [NSLV:0]          s_ibp_rd_last,
  input  logic [(NSLV+1)*DW-1:0] s_ibp_rd_data,
  output logic [NSLV:0]          s_ibp_rd_accept,
  output logic [NSLV:0]          s_ibp_wr_valid,
  output logic [NSLV:0]          s_ibp_wr_last,
  output logic [DW-1:0]          s_ibp_wr_data,
  output logic [DW/8-1:0]        s_ibp_wr_mask,
  input  logic [NSLV:0]          s_ibp_wr_accept,
  input  logic [NSLV:0]          s_ibp_wr_done,
  input  logic [NSLV:0]          s_ibp_wr_excl_done,
  input  logic [NSLV:0]          s_ibp_err_wr,
  output logic [NSLV:0]          s_ibp_wr_resp_accept
);
  localparam int NP  = NSLV + 1;
  localparam int IDW = port_id_w(NP);

  logic [IDW-1:0] sel, rd_head, wd_head, wr_head;
  logic rd_full, rd_empty, wd_full, wd_empty, wr_full, wr_empty;
  logic cmd_stall, cmd_hs, rd_pop, wd_pop, wr_pop;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel = IDW'(NSLV);
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((m_ibp_cmd_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) sel = IDW'(i);
    end
  end

  assign cmd_stall = m_ibp_cmd_read ? rd_full : (wd_full | wr_full);

  always_comb begin
    s_ibp_cmd_valid  = '0;
    m_ibp_cmd_accept = 1'b0;
    if (!cmd_stall) begin
      s_ibp_cmd_valid[sel] = m_ibp_cmd_valid;
      m_ibp_cmd_accept     = s_ibp_cmd_accept[sel];
    end
  end

  assign cmd_hs               = m_ibp_cmd_valid & m_ibp_cmd_accept;
  assign s_ibp_cmd_read       = m_ibp_cmd_read;
  assign s_ibp_cmd_addr       = m_ibp_cmd_addr;
  assign s_ibp_cmd_wrap       = m_ibp_cmd_wrap;
  assign s_ibp_cmd_data_size  = m_ibp_cmd_data_size;
  assign s_ibp_cmd_burst_size = m_ibp_cmd_burst_size;
  assign s_ibp_cmd_prot       = m_ibp_cmd_prot;
  assign s_ibp_cmd_cache      = m_ibp_cmd_cache;
  assign s_ibp_cmd_lock       = m_ibp_cmd_lock;
  assign s_ibp_cmd_excl       = m_ibp_cmd_excl;
  assign s_ibp_wr_data        = m_ibp_wr_data;
  assign s_ibp_wr_mask        = m_ibp_wr_mask;

  mss_bus_switch_ord_fifo #(.IDW(IDW), .DEPTH(OUT_DEPTH)) u_rd_fifo (
    .clk, .rst_a, .push_i(cmd_hs & m_ibp_cmd_read), .id_i(sel), .pop_i(rd_pop),
    .full_o(rd_full), .empty_o(rd_empty), .head_o(rd_head));

  mss_bus_switch_ord_fifo #(.IDW(IDW), .DEPTH(OUT_DEPTH)) u_wd_fifo (
    .clk, .rst_a, .push_i(cmd_hs & ~m_ibp_cmd_read), .id_i(sel), .pop_i(wd_pop),
    .full_o(wd_full), .empty_o(wd_empty), .head_o(wd_head));

  mss_bus_switch_ord_fifo #(.IDW(IDW), .DEPTH(OUT_DEPTH)) u_wr_fifo (
    .clk, .rst_a, .push_i(cmd_hs & ~m_ibp_cmd_read), .id_i(sel), .pop_i(wr_pop),
    .full_o(wr_full), .empty_o(wr_empty), .head_o(wr_head));

  // Write beats only flow once their command sits at the wd_fifo head.
  always_comb begin
    s_ibp_wr_valid  = '0;
    s_ibp_wr_last   = '0;
    m_ibp_wr_accept = 1'b0;
    if (!wd_empty) begin
      s_ibp_wr_valid[wd_head] = m_ibp_wr_valid;
      s_ibp_wr_last[wd_head]  = m_ibp_wr_last;
      m_ibp_wr_accept         = s_ibp_wr_accept[wd_head];
    end
  end

  assign wd_pop = m_ibp_wr_valid & m_ibp_wr_accept & m_ibp_wr_last;

  always_comb begin
    m_ibp_rd_valid   = 1'b0;
    m_ibp_rd_excl_ok = 1'b0;
    m_ibp_err_rd     = 1'b0;
    m_ibp_rd_last    = 1'b0;
    m_ibp_rd_data    = '0;
    s_ibp_rd_accept  = '0;
    if (!rd_empty) begin
      m_ibp_rd_valid           = s_ibp_rd_valid[rd_head];
      m_ibp_rd_excl_ok         = s_ibp_rd_excl_ok[rd_head];
      m_ibp_err_rd             = s_ibp_err_rd[rd_head];
      m_ibp_rd_last            = s_ibp_rd_last[rd_head];
      m_ibp_rd_data            = s_ibp_rd_data[int'(rd_head)*DW +: DW];
      s_ibp_rd_accept[rd_head] = m_ibp_rd_accept;
    end
  end

  assign rd_pop = (m_ibp_rd_valid | m_ibp_err_rd) & m_ibp_rd_accept & m_ibp_rd_last;

  always_comb begin
    m_ibp_wr_done        = 1'b0;
    m_ibp_wr_excl_done   = 1'b0;
    m_ibp_err_wr         = 1'b0;
    s_ibp_wr_resp_accept = '0;
    if (!wr_empty) begin
      m_ibp_wr_done                 = s_ibp_wr_done[wr_head];
      m_ibp_wr_excl_done            = s_ibp_wr_excl_done[wr_head];
      m_ibp_err_wr                  = s_ibp_err_wr[wr_head];
      s_ibp_wr_resp_accept[wr_head] = m_ibp_wr_resp_accept;
    end
  end

  assign wr_pop = (m_ibp_wr_done | m_ibp_wr_excl_done | m_ibp_err_wr) & m_ibp_wr_resp_accept;

endmodule

// File: tb/tb_mss_bus_switch_ibp_dec.sv
// Scoreboard bench for the IBP decoder: stimulus queues expected commands,
// beats and responses; one negedge monitor compares them as they appear.
module tb_mss_bus_switch_ibp_dec;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst_a;
  always #5 clk = ~clk;

  logic m_ibp_cmd_valid, m_ibp_cmd_accept, m_ibp_cmd_read, m_ibp_cmd_wrap, m_ibp_cmd_lock, m_ibp_cmd_excl;
  logic [AW-1:0] m_ibp_cmd_addr;
  logic [2:0] m_ibp_cmd_data_size;
  logic [3:0] m_ibp_cmd_burst_size, m_ibp_cmd_cache;
  logic [1:0] m_ibp_cmd_prot;
  logic m_ibp_rd_valid, m_ibp_rd_excl_ok, m_ibp_err_rd, m_ibp_rd_last, m_ibp_rd_accept;
  logic [DW-1:0] m_ibp_rd_data, m_ibp_wr_data;
  logic m_ibp_wr_valid, m_ibp_wr_last, m_ibp_wr_accept;
  logic [DW/8-1:0] m_ibp_wr_mask;
  logic m_ibp_wr_done, m_ibp_wr_excl_done, m_ibp_err_wr, m_ibp_wr_resp_accept;
  logic [NP-1:0] s_ibp_cmd_valid, s_ibp_cmd_accept;
  logic s_ibp_cmd_read, s_ibp_cmd_wrap, s_ibp_cmd_lock, s_ibp_cmd_excl;
  logic [AW-1:0] s_ibp_cmd_addr;
  logic [2:0] s_ibp_cmd_data_size;
  logic [3:0] s_ibp_cmd_burst_size, s_ibp_cmd_cache;
  logic [1:0] s_ibp_cmd_prot;
  logic [NP-1:0] s_ibp_rd_valid, s_ibp_rd_excl_ok, s_ibp_err_rd, s_ibp_rd_last, s_ibp_rd_accept;
  logic [NP*DW-1:0] s_ibp_rd_data;
  logic [NP-1:0] s_ibp_wr_valid, s_ibp_wr_last, s_ibp_wr_accept;
  logic [DW-1:0] s_ibp_wr_data;
  logic [DW/8-1:0] s_ibp_wr_mask;
  logic [NP-1:0] s_ibp_wr_done, s_ibp_wr_excl_done, s_ibp_err_wr, s_ibp_wr_resp_accept;

  mss_bus_switch_ibp_dec #(
    .AW(AW), .DW(DW), .NSLV(2),
    .SLV_BASE(64'h2000_0000_1000_0000),
    .SLV_MASK(64'hF000_0000_F000_0000),
    .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst_a(rst_a),
    .m_ibp_cmd_valid(m_ibp_cmd_valid), .m_ibp_cmd_accept(m_ibp_cmd_accept),
    .m_ibp_cmd_read(m_ibp_cmd_read), .m_ibp_cmd_addr(m_ibp_cmd_addr), .m_ibp_cmd_wrap(m_ibp_cmd_wrap),
    .m_ibp_cmd_data_size(m_ibp_cmd_data_size), .m_ibp_cmd_burst_size(m_ibp_cmd_burst_size),
    .m_ibp_cmd_prot(m_ibp_cmd_prot), .m_ibp_cmd_cache(m_ibp_cmd_cache),
    .m_ibp_cmd_lock(m_ibp_cmd_lock), .m_ibp_cmd_excl(m_ibp_cmd_excl),
    .m_ibp_rd_valid(m_ibp_rd_valid), .m_ibp_rd_excl_ok(m_ibp_rd_excl_ok), .m_ibp_err_rd(m_ibp_err_rd),
    .m_ibp_rd_last(m_ibp_rd_last), .m_ibp_rd_data(m_ibp_rd_data), .m_ibp_rd_accept(m_ibp_rd_accept),
    .m_ibp_wr_valid(m_ibp_wr_valid), .m_ibp_wr_last(m_ibp_wr_last), .m_ibp_wr_data(m_ibp_wr_data),
    .m_ibp_wr_mask(m_ibp_wr_mask), .m_ibp_wr_accept(m_ibp_wr_accept),
    .m_ibp_wr_done(m_ibp_wr_done), .m_ibp_wr_excl_done(m_ibp_wr_excl_done), .m_ibp_err_wr(m_ibp_err_wr),
    .m_ibp_wr_resp_accept(m_ibp_wr_resp_accept),
    .s_ibp_cmd_valid(s_ibp_cmd_valid), .s_ibp_cmd_accept(s_ibp_cmd_accept),
    .s_ibp_cmd_read(s_ibp_cmd_read), .s_ibp_cmd_addr(s_ibp_cmd_addr), .s_ibp_cmd_wrap(s_ibp_cmd_wrap),
    .s_ibp_cmd_data_size(s_ibp_cmd_data_size), .s_ibp_cmd_burst_size(s_ibp_cmd_burst_size),
    .s_ibp_cmd_prot(s_ibp_cmd_prot), .s_ibp_cmd_cache(s_ibp_cmd_cache),
    .s_ibp_cmd_lock(s_ibp_cmd_lock), .s_ibp_cmd_excl(s_ibp_cmd_excl),
    .s_ibp_rd_valid(s_ibp_rd_valid), .s_ibp_rd_excl_ok(s_ibp_rd_excl_ok), .s_ibp_err_rd(s_ibp_err_rd),
    .s_ibp_rd_last(s_ibp_rd_last), .s_ibp_rd_data(s_ibp_rd_data), .s_ibp_rd_accept(s_ibp_rd_accept),
    .s_ibp_wr_valid(s_ibp_wr_valid), .s_ibp_wr_last(s_ibp_wr_last), .s_ibp_wr_data(s_ibp_wr_data),
    .s_ibp_wr_mask(s_ibp_wr_mask), .s_ibp_wr_accept(s_ibp_wr_accept),
    .s_ibp_wr_done(s_ibp_wr_done), .s_ibp_wr_excl_done(s_ibp_wr_excl_done), .s_ibp_err_wr(s_ibp_err_wr),
    .s_ibp_wr_resp_accept(s_ibp_wr_resp_accept)
  );

  int checks = 0;
  int errors = 0;

  logic [NP-1:0]   exp_cmd_q[$];
  logic [66:0]     exp_rd_q[$];
  logic [66:0]     exp_wd_q[$];
  logic [2:0]      exp_wresp_q[$];
  string           dq_name[$];
  logic [79:0]     dq_act[$];
  logic [79:0]     dq_exp[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Direct observations from stimulus are queued and compared by the monitor.
  task automatic dchk(input string name, input logic [79:0] act, input logic [79:0] exp);
    dq_name.push_back(name);
    dq_act.push_back(act);
    dq_exp.push_back(exp);
  endtask

  always @(negedge clk) begin
    while (dq_name.size() > 0) check(dq_name.pop_front(), dq_act.pop_front(), dq_exp.pop_front());
    if (!rst_a) begin
      if (|(s_ibp_cmd_valid & s_ibp_cmd_accept)) begin
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", 80'(s_ibp_cmd_valid), 80'd0);
        else check("cmd_port", 80'(s_ibp_cmd_valid), 80'(exp_cmd_q.pop_front()));
      end
      if ((m_ibp_rd_valid | m_ibp_err_rd) & m_ibp_rd_accept) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 80'(m_ibp_rd_data), 80'd0);
        else check("rd_beat", 80'({m_ibp_rd_data, m_ibp_rd_valid, m_ibp_err_rd, m_ibp_rd_last}),
                   80'(exp_rd_q.pop_front()));
      end
      if (|(s_ibp_wr_valid & s_ibp_wr_accept)) begin
        if (exp_wd_q.size() == 0) check("wd_unexpected", 80'(s_ibp_wr_valid), 80'd0);
        else check("wr_beat", 80'({s_ibp_wr_valid, s_ibp_wr_data}), 80'(exp_wd_q.pop_front()));
      end
      if ((m_ibp_wr_done | m_ibp_wr_excl_done | m_ibp_err_wr) & m_ibp_wr_resp_accept) begin
        if (exp_wresp_q.size() == 0) check("wresp_unexpected", 80'(m_ibp_wr_done), 80'd0);
        else check("wr_resp", 80'({m_ibp_wr_done, m_ibp_wr_excl_done, m_ibp_err_wr}),
                   80'(exp_wresp_q.pop_front()));
      end
    end
  end

  task automatic send_cmd(input logic rd, input logic [AW-1:0] a, input logic [3:0] bsz,
                          input logic [NP-1:0] exp_oh);
    int n = 0;
    exp_cmd_q.push_back(exp_oh);
    m_ibp_cmd_valid = 1'b1; m_ibp_cmd_read = rd; m_ibp_cmd_addr = a; m_ibp_cmd_burst_size = bsz;
    forever begin
      @(negedge clk);
      if (m_ibp_cmd_accept) break;
      if (++n > 50) begin dchk("cmd_timeout", 80'd0, 80'd1); break; end
    end
    @(posedge clk); #1;
    m_ibp_cmd_valid = 1'b0;
  endtask

  task automatic exp_rd(input int n, input logic [63:0] d0, input logic err);
    for (int b = 0; b < n; b++)
      exp_rd_q.push_back({err ? 64'd0 : d0 + 64'(b), ~err, err, b == n - 1});
  endtask

  task automatic drive_rd(input int p, input int n, input logic [63:0] d0, input logic err);
    for (int b = 0; b < n; b++) begin
      int t = 0;
      s_ibp_rd_valid[p] = ~err;
      s_ibp_err_rd[p]   = err;
      s_ibp_rd_last[p]  = (b == n - 1);
      s_ibp_rd_data[p*DW +: DW] = err ? 64'd0 : d0 + 64'(b);
      forever begin
        @(negedge clk);
        if (s_ibp_rd_accept[p]) break;
        if (++t > 60) begin dchk("rd_accept_timeout", 80'(p), 80'hFF); break; end
      end
      @(posedge clk); #1;
    end
    s_ibp_rd_valid[p] = 1'b0; s_ibp_err_rd[p] = 1'b0; s_ibp_rd_last[p] = 1'b0;
    s_ibp_rd_data[p*DW +: DW] = '0;
  endtask

  task automatic drive_wr(input logic [63:0] d, input logic last);
    int t = 0;
    m_ibp_wr_valid = 1'b1; m_ibp_wr_data = d; m_ibp_wr_last = last;
    forever begin
      @(negedge clk);
      if (m_ibp_wr_accept) break;
      if (++t > 50) begin dchk("wr_accept_timeout", 80'd0, 80'd1); break; end
    end
    @(posedge clk); #1;
    m_ibp_wr_valid = 1'b0; m_ibp_wr_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    {m_ibp_cmd_valid, m_ibp_cmd_read, m_ibp_cmd_wrap, m_ibp_cmd_lock, m_ibp_cmd_excl} = '0;
    m_ibp_cmd_addr = '0; m_ibp_cmd_data_size = 3'd3; m_ibp_cmd_burst_size = '0;
    m_ibp_cmd_prot = '0; m_ibp_cmd_cache = '0;
    m_ibp_rd_accept = 1'b0; m_ibp_wr_valid = 1'b0; m_ibp_wr_last = 1'b0;
    m_ibp_wr_data = '0; m_ibp_wr_mask = '1; m_ibp_wr_resp_accept = 1'b0;
    s_ibp_cmd_accept = '0; s_ibp_rd_valid = '0; s_ibp_rd_excl_ok = '0; s_ibp_err_rd = '0;
    s_ibp_rd_last = '0; s_ibp_rd_data = '0; s_ibp_wr_accept = '0;
    s_ibp_wr_done = '0; s_ibp_wr_excl_done = '0; s_ibp_err_wr = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;

    // Reset state: responses offered on every port must not reach the master.
    s_ibp_rd_valid = '1; s_ibp_wr_done = '1; m_ibp_rd_accept = 1'b1;
    m_ibp_wr_resp_accept = 1'b1; m_ibp_wr_valid = 1'b1;
    @(negedge clk);
    dchk("rst_rd_valid", 80'(m_ibp_rd_valid), 80'd0);
    dchk("rst_wr_done", 80'(m_ibp_wr_done), 80'd0);
    dchk("rst_wr_accept", 80'(m_ibp_wr_accept), 80'd0);
    dchk("rst_rd_acc", 80'(s_ibp_rd_accept), 80'd0);
    dchk("rst_wresp_acc", 80'(s_ibp_wr_resp_accept), 80'd0);
    dchk("rst_cmd_accept", 80'(m_ibp_cmd_accept), 80'd0);
    @(posedge clk); #1;
    s_ibp_rd_valid = '0; s_ibp_wr_done = '0; m_ibp_wr_valid = 1'b0;
    s_ibp_cmd_accept = '1; s_ibp_wr_accept = '1;

    // 4-beat read to port 0, then the FIFO must be empty again.
    send_cmd(1'b1, 32'h1000_0040, 4'd3, 3'b001);
    exp_rd(4, 64'hA0A0_0000_0000_0010, 1'b0);
    drive_rd(0, 4, 64'hA0A0_0000_0000_0010, 1'b0);
    s_ibp_rd_valid[0] = 1'b1; s_ibp_rd_data[0 +: DW] = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    dchk("rd_empty_valid", 80'(m_ibp_rd_valid), 80'd0);
    dchk("rd_empty_data", 80'(m_ibp_rd_data), 80'd0);
    dchk("rd_empty_acc", 80'(s_ibp_rd_accept), 80'd0);
    @(posedge clk); #1;
    s_ibp_rd_valid[0] = 1'b0; s_ibp_rd_data[0 +: DW] = '0;

    // Unmapped address goes to the default slave; error beats return.
    send_cmd(1'b1, 32'h5000_0000, 4'd1, 3'b100);
    exp_rd(2, 64'd0, 1'b1);
    drive_rd(2, 2, 64'd0, 1'b1);

    // Ordering: port1 then port0; port0 answers early and must be held off.
    send_cmd(1'b1, 32'h2000_0010, 4'd1, 3'b010);
    send_cmd(1'b1, 32'h1000_0020, 4'd1, 3'b001);
    exp_rd(2, 64'hB1B1_0000_0000_0000, 1'b0);
    exp_rd(2, 64'hC0C0_0000_0000_0000, 1'b0);
    fork
      drive_rd(0, 2, 64'hC0C0_0000_0000_0000, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_rd(1, 2, 64'hB1B1_0000_0000_0000, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        dchk("order_hold_acc0", 80'(s_ibp_rd_accept[0]), 80'd0);
        dchk("order_hold_valid", 80'(m_ibp_rd_valid), 80'd0);
      end
    join

    // Write data offered before its command must wait.
    m_ibp_wr_valid = 1'b1; m_ibp_wr_data = 64'h1111_2222_3333_4444; m_ibp_wr_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dchk("wr_early_accept", 80'(m_ibp_wr_accept), 80'd0);
      dchk("wr_early_valid", 80'(s_ibp_wr_valid), 80'd0);
      @(posedge clk); #1;
    end
    exp_wd_q.push_back({3'b001, 64'h1111_2222_3333_4444});
    exp_wd_q.push_back({3'b001, 64'h5555_6666_7777_8888});
    exp_wresp_q.push_back(3'b100);
    send_cmd(1'b0, 32'h1000_0100, 4'd1, 3'b001);
    drive_wr(64'h1111_2222_3333_4444, 1'b0);
    drive_wr(64'h5555_6666_7777_8888, 1'b1);
    fork
      begin
        int t = 0;
        s_ibp_wr_done[0] = 1'b1;
        forever begin
          @(negedge clk);
          if (s_ibp_wr_resp_accept[0]) break;
          if (++t > 50) begin dchk("wresp_timeout", 80'd0, 80'd1); break; end
        end
        @(posedge clk); #1;
      end
    join
    @(negedge clk);
    dchk("wr_done_once", 80'(m_ibp_wr_done), 80'd0);
    dchk("wr_done_once_acc", 80'(s_ibp_wr_resp_accept), 80'd0);
    @(posedge clk); #1;
    s_ibp_wr_done[0] = 1'b0;

    // Depth 4: the fifth outstanding read stalls until the first pops.
    m_ibp_rd_accept = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(1'b1, 32'h2000_0000 + 32'(i * 64), 4'd0, 3'b010);
    exp_cmd_q.push_back(3'b010);
    m_ibp_cmd_valid = 1'b1; m_ibp_cmd_read = 1'b1; m_ibp_cmd_addr = 32'h2000_1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dchk("full_cmd_accept", 80'(m_ibp_cmd_accept), 80'd0);
      dchk("full_cmd_valid", 80'(s_ibp_cmd_valid), 80'd0);
      @(posedge clk); #1;
    end
    m_ibp_rd_accept = 1'b1;
    exp_rd(1, 64'hD000_0000_0000_0000, 1'b0);
    drive_rd(1, 1, 64'hD000_0000_0000_0000, 1'b0);
    @(negedge clk);
    dchk("full_release_accept", 80'(m_ibp_cmd_accept), 80'd1);
    @(posedge clk); #1;
    m_ibp_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_rd(1, 64'hD100_0000_0000_0000 + 64'(i * 16), 1'b0);
      drive_rd(1, 1, 64'hD100_0000_0000_0000 + 64'(i * 16), 1'b0);
    end

    // Mid-burst reset with two reads outstanding.
    send_cmd(1'b1, 32'h1000_0000, 4'd3, 3'b001);
    send_cmd(1'b1, 32'h2000_0000, 4'd0, 3'b010);
    exp_rd_q.push_back({64'hE000_0000_0000_0000, 1'b1, 1'b0, 1'b0});
    s_ibp_rd_valid[0] = 1'b1; s_ibp_rd_last[0] = 1'b0; s_ibp_rd_data[0 +: DW] = 64'hE000_0000_0000_0000;
    @(negedge clk);
    @(posedge clk); #1;
    m_ibp_rd_accept = 1'b0; s_ibp_rd_data[0 +: DW] = 64'hE000_0000_0000_0001;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0; m_ibp_rd_accept = 1'b1; m_ibp_wr_valid = 1'b1;
    @(negedge clk);
    dchk("midrst_rd_valid", 80'(m_ibp_rd_valid), 80'd0);
    dchk("midrst_rd_data", 80'(m_ibp_rd_data), 80'd0);
    dchk("midrst_rd_acc", 80'(s_ibp_rd_accept), 80'd0);
    dchk("midrst_wr_accept", 80'(m_ibp_wr_accept), 80'd0);
    @(posedge clk); #1;
    s_ibp_rd_valid[0] = 1'b0; s_ibp_rd_data[0 +: DW] = '0; m_ibp_wr_valid = 1'b0;
    s_ibp_cmd_accept = 3'b010;
    m_ibp_cmd_valid = 1'b1; m_ibp_cmd_read = 1'b1; m_ibp_cmd_addr = 32'h1000_0200;
    @(negedge clk);
    dchk("midrst_dec0_accept", 80'(m_ibp_cmd_accept), 80'd0);
    dchk("midrst_dec0_valid", 80'(s_ibp_cmd_valid), 80'b001);
    dchk("cmd_addr_bcast", 80'(s_ibp_cmd_addr), 80'h1000_0200);
    @(posedge clk); #1;
    exp_cmd_q.push_back(3'b010);
    m_ibp_cmd_addr = 32'h2000_0200;
    @(negedge clk);
    dchk("midrst_dec1_accept", 80'(m_ibp_cmd_accept), 80'd1);
    @(posedge clk); #1;
    m_ibp_cmd_valid = 1'b0; s_ibp_cmd_accept = '1;
    exp_rd(1, 64'hF000_0000_0000_0000, 1'b0);
    drive_rd(1, 1, 64'hF000_0000_0000_0000, 1'b0);

    repeat (3) @(negedge clk);
    dchk("cmd_q_drained", 80'(exp_cmd_q.size()), 80'd0);
    dchk("rd_q_drained", 80'(exp_rd_q.size()), 80'd0);
    dchk("wd_q_drained", 80'(exp_wd_q.size()), 80'd0);
    dchk("wresp_q_drained", 80'(exp_wresp_q.size()), 80'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
